cgra_data_bus_responder: RTL and testbench



---
 rtl/cgra_data_bus_responder.sv | 134 +++++++++++++
 tb/tb_cgra_data_bus_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_data_bus_responder.sv
// Memory-side responder for one CGRA data-bus column: grants req/gnt/rvalid
// accesses after a programmable wait into a word-addressed SRAM model.
module cgra_data_bus_responder #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned ADD_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [ADD_WIDTH-1:0]  add_i,
  input  logic                  wen_i,
  input  logic [3:0]            be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [3:0]            gnt_wait_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned NB    = DATA_WIDTH / 8;

  typedef enum logic {G_IDLE, G_WAIT} gnt_state_e;

  gnt_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      G_IDLE: begin
        if (req_i) begin
          if (gnt_wait_i == 4'd0) begin
            gnt = 1'b1;
          end else begin
            cnt_d   = gnt_wait_i - 4'd1;
            state_d = G_WAIT;
          end
        end
      end
      G_WAIT: begin
        // A dropped request abandons the wait without touching memory.
        if (!req_i) begin
          state_d = G_IDLE;
        end else if (cnt_q == 4'd0) begin
          gnt     = 1'b1;
          state_d = G_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = G_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= G_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o = gnt;

  // Word index plus error on misalignment or any address bit above the index field.
  logic [IDX_W-1:0] idx;
  logic             addr_err;
  assign idx      = add_i[2 +: IDX_W];
  assign addr_err = (add_i[1:0] != 2'b00) || ((add_i >> (IDX_W + 2)) != '0);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  assign wr_en   = gnt & ~wen_i & ~addr_err;
  assign rd_en   = gnt & wen_i;
  assign rd_word = addr_err ? '0 : mem_q[idx];

  // NOTE: the memory array has no reset so it maps onto a plain SRAM and keeps contents across rst_ni.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  logic [RD_LAT-1:0]     vld_q;
  logic [RD_LAT-1:0]     rerr_q;
  logic [DATA_WIDTH-1:0] rdat_q [RD_LAT];
  logic                  werr_q;

  // Data stages only load behind a valid word, so the last stage holds the
  // most recent response between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      rerr_q <= '0;
      werr_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) rdat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_en;
      werr_q   <= gnt & ~wen_i & addr_err;
      if (rd_en) begin
        rdat_q[0] <= rd_word;
        rerr_q[0] <= addr_err;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          rdat_q[i] <= rdat_q[i-1];
          rerr_q[i] <= rerr_q[i-1];
        end
      end
    end
  end

  assign rvalid_o = vld_q[RD_LAT-1];
  assign rdata_o  = rdat_q[RD_LAT-1];
  assign err_o    = (vld_q[RD_LAT-1] & rerr_q[RD_LAT-1]) | werr_q;

endmodule

// File: tb/tb_cgra_data_bus_responder.sv
// Drives identical traffic into an RD_LAT=1 and an RD_LAT=4 responder and
// scores both against a byte-lane memory model and expected response cycles.
module tb_cgra_data_bus_responder;

  localparam int MEM_WORDS = 1024;
  localparam int IDXW      = $clog2(MEM_WORDS);
  localparam int LAT4      = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          gcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] add = '0;
  logic        wen = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt_wait = '0;

  logic [1:0]  gnt, rv, er;
  logic [31:0] rd [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t        rq[$];
  int          wq[$];
  int          p[2] = '{0, 0};
  logic [31:0] model [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cgra_data_bus_responder #(.MEM_WORDS(MEM_WORDS), .RD_LAT(1)) u_dut_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
    .wdata_i(wdata), .gnt_wait_i(gnt_wait), .gnt_o(gnt[0]), .rvalid_o(rv[0]),
    .rdata_o(rd[0]), .err_o(er[0])
  );

  cgra_data_bus_responder #(.MEM_WORDS(MEM_WORDS), .RD_LAT(LAT4)) u_dut_lat4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
    .wdata_i(wdata), .gnt_wait_i(gnt_wait), .gnt_o(gnt[1]), .rvalid_o(rv[1]),
    .rdata_o(rd[1]), .err_o(er[1])
  );

  function automatic bit addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * MEM_WORDS));
  endfunction

  // Scoreboard push at grant: reads queue their expected word, writes update the model.
  task automatic expect_grant(input logic w, input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d);
    exp_t        e;
    int          i;
    logic [31:0] old;
    i = int'(a[2 +: IDXW]);
    if (addr_err(a)) begin
      if (w) begin
        e.data = 32'h0; e.err = 1'b1; e.gcyc = cyc;
        rq.push_back(e);
      end else begin
        wq.push_back(cyc + 1);
      end
    end else if (w) begin
      e.data = model.exists(i) ? model[i] : 32'h0;
      e.err  = 1'b0;
      e.gcyc = cyc;
      rq.push_back(e);
    end else begin
      old = model.exists(i) ? model[i] : 32'h0;
      for (int k = 0; k < 4; k++) if (b[k]) old[8*k +: 8] = d[8*k +: 8];
      model[i] = old;
    end
  endtask

  // Raises a request and holds it until granted; returns wait cycles and grant cycle.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [3:0] gw,
                        output int n, output int g);
    req = 1'b1; wen = w; add = a; be = b; wdata = d; gnt_wait = gw;
    n = 0;
    g = -1;
    forever begin
      @(negedge clk);
      checks++;
      if (gnt[0] !== gnt[1]) begin
        failures++;
        $display("FAIL gnt_match lat1=%b lat4=%b cycle=%0d", gnt[0], gnt[1], cyc);
      end
      if (gnt[0] === 1'b1) break;
      n++;
      if (n > 40) begin
        failures++;
        $display("FAIL grant_timeout addr=%h waited=%0d required<=%0d", a, n, gw);
        break;
      end
    end
    if (n <= 40) begin
      g = cyc;
      expect_grant(w, a, b, d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    req = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Response monitor: every rvalid must match the next queued read at its exact cycle.
  always @(negedge clk) begin : monitor
    logic pulse;
    int   lat;
    exp_t e;
    if (rst_n) begin
      pulse = (wq.size() > 0) && (wq[0] == cyc);
      for (int k = 0; k < 2; k++) begin
        lat = (k == 0) ? 1 : LAT4;
        if (rv[k] === 1'b1) begin
          checks++;
          if (p[k] >= rq.size()) begin
            failures++;
            $display("FAIL rsp_unexpected dut%0d cycle=%0d data=%h err=%b", k, cyc, rd[k], er[k]);
          end else begin
            e = rq[p[k]];
            p[k]++;
            if (cyc != e.gcyc + lat || rd[k] !== e.data || er[k] !== (e.err | pulse)) begin
              failures++;
              $display("FAIL rsp dut%0d got cyc=%0d data=%h err=%b required cyc=%0d data=%h err=%b",
                       k, cyc, rd[k], er[k], e.gcyc + lat, e.data, e.err | pulse);
            end
          end
        end else begin
          checks++;
          if (rv[k] !== 1'b0 || er[k] !== pulse) begin
            failures++;
            $display("FAIL idle_flags dut%0d cycle=%0d rvalid=%b err=%b required rvalid=0 err=%b",
                     k, cyc, rv[k], er[k], pulse);
          end
          if (p[k] < rq.size()) begin
            checks++;
            if (rq[p[k]].gcyc + lat <= cyc) begin
              failures++;
              $display("FAIL rsp_missing dut%0d cycle=%0d required at cyc=%0d", k, cyc,
                       rq[p[k]].gcyc + lat);
              p[k]++;
            end
          end
        end
      end
      if (pulse) void'(wq.pop_front());
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    p[0]  = rq.size();
    p[1]  = rq.size();
    wq.delete();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({gnt[k], rv[k], rd[k], er[k]} !== 35'h0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d gnt=%b rvalid=%b rdata=%h err=%b required all 0",
                 k, gnt[k], rv[k], rd[k], er[k]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n, g;
    access(1'b0, 32'h10, 4'hF, 32'hCAFEBABE, 4'd0, n, g);
    checks++;
    if (n != 0) begin failures++; $display("FAIL basic_wr_gnt waited=%0d required=0", n); end
    access(1'b1, 32'h10, 4'h0, 32'h0, 4'd0, n, g);
    checks++;
    if (n != 0) begin failures++; $display("FAIL basic_rd_gnt waited=%0d required=0", n); end
    idle(8);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd[k] !== 32'hCAFEBABE || rv[k] !== 1'b0) begin
        failures++;
        $display("FAIL rdata_hold dut%0d rdata=%h rvalid=%b required rdata=cafebabe rvalid=0",
                 k, rd[k], rv[k]);
      end
    end
  endtask

  task automatic test_byte_enables();
    int n, g;
    access(1'b0, 32'h20, 4'hF, 32'hFFFFFFFF, 4'd0, n, g);
    access(1'b0, 32'h20, 4'b0101, 32'h00000000, 4'd0, n, g);
    access(1'b1, 32'h20, 4'b0101, 32'h0, 4'd0, n, g);
    checks++;
    if (model[8] !== 32'hFF00FF00) begin
      failures++;
      $display("FAIL be_model word=%h required=ff00ff00", model[8]);
    end
    idle(6);
  endtask

  task automatic test_wait();
    int n, g, g0;
    access(1'b0, 32'h30, 4'hF, 32'hA5A5A5A5, 4'd3, n, g);
    checks++;
    if (n != 3) begin failures++; $display("FAIL wait3 waited=%0d required=3", n); end
    idle(1);
    access(1'b1, 32'h30, 4'h0, 32'h0, 4'd1, n, g);
    checks++;
    if (n != 1) begin failures++; $display("FAIL wait1 waited=%0d required=1", n); end
    idle(1);
    // Wait value changed mid-wait must not shorten the grant delay.
    req = 1'b1; wen = 1'b1; add = 32'h10; be = 4'h0; gnt_wait = 4'd3;
    @(negedge clk);
    g0 = cyc;
    @(posedge clk);
    #1;
    gnt_wait = 4'd0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (gnt[0] === 1'b1 && gnt[1] === 1'b1) break;
      n++;
    end
    checks++;
    if (cyc - g0 != 3) begin
      failures++;
      $display("FAIL wait_change grant_after=%0d required=3", cyc - g0);
    end
    if (n < 20) expect_grant(1'b1, 32'h10, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    access(1'b1, 32'h30, 4'h0, 32'h0, 4'd0, n, g);
    checks++;
    if (n != 0) begin failures++; $display("FAIL wait_next waited=%0d required=0", n); end
    idle(6);
  endtask

  task automatic test_req_drop();
    int n, g;
    req = 1'b1; wen = 1'b0; add = 32'h30; be = 4'hF; wdata = 32'h12345678; gnt_wait = 4'd3;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00) begin failures++; $display("FAIL drop_gnt0 gnt=%b required=00", gnt); end
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00) begin failures++; $display("FAIL drop_gnt1 gnt=%b required=00", gnt); end
    @(posedge clk);
    #1;
    access(1'b1, 32'h30, 4'h0, 32'h0, 4'd0, n, g);
    checks++;
    if (n != 0) begin failures++; $display("FAIL drop_idle waited=%0d required=0", n); end
    idle(6);
  endtask

  task automatic test_back_to_back();
    int n;
    int g[4];
    for (int i = 0; i < 4; i++) access(1'b0, 32'(4 * i), 4'hF, 32'(i + 1), 4'd0, n, g[i]);
    for (int i = 0; i < 4; i++) access(1'b1, 32'(4 * i), 4'h0, 32'h0, 4'd0, n, g[i]);
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (g[i] != g[0] + i) begin
        failures++;
        $display("FAIL b2b_grant idx=%0d cyc=%0d required=%0d", i, g[i], g[0] + i);
      end
    end
    idle(6);
    // In-flight read keeps old data; immediate re-read sees the write; bad
    // write's err pulse lands on the LAT4 rvalid of the second read.
    access(1'b1, 32'h0, 4'h0, 32'h0, 4'd0, n, g[0]);
    access(1'b1, 32'h4, 4'h0, 32'h0, 4'd0, n, g[0]);
    access(1'b0, 32'h4, 4'hF, 32'h00000055, 4'd0, n, g[0]);
    access(1'b1, 32'h4, 4'h0, 32'h0, 4'd0, n, g[0]);
    access(1'b0, 32'h1000, 4'hF, 32'hDEADBEEF, 4'd0, n, g[0]);
    access(1'b1, 32'h0, 4'h0, 32'h0, 4'd0, n, g[0]);
    idle(6);
  endtask

  task automatic test_errors();
    int n, g;
    access(1'b1, 32'h2, 4'hF, 32'h0, 4'd0, n, g);
    idle(6);
    access(1'b0, 32'(4 * MEM_WORDS), 4'hF, 32'h87654321, 4'd0, n, g);
    idle(6);
    access(1'b0, 32'h31, 4'hF, 32'h87654321, 4'd0, n, g);
    access(1'b1, 32'h0, 4'h0, 32'h0, 4'd0, n, g);
    access(1'b1, 32'h30, 4'h0, 32'h0, 4'd0, n, g);
    idle(6);
  endtask

  task automatic test_reset_midflight();
    int n, g;
    access(1'b1, 32'h10, 4'h0, 32'h0, 4'd0, n, g);
    access(1'b1, 32'h20, 4'h0, 32'h0, 4'd0, n, g);
    test_reset();
    idle(8);
    access(1'b1, 32'h10, 4'h0, 32'h0, 4'd0, n, g);
    access(1'b1, 32'h20, 4'h0, 32'h0, 4'd0, n, g);
    idle(8);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_enables();
    test_wait();
    test_req_drop();
    test_back_to_back();
    test_errors();
    test_reset_midflight();
    idle(4);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (p[k] != rq.size()) begin
        failures++;
        $display("FAIL drained dut%0d consumed=%0d required=%0d", k, p[k], rq.size());
      end
    end
    checks++;
    if (wq.size() != 0) begin
      failures++;
      $display("FAIL werr_drained pending=%0d required=0", wq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
